freq_result_calc: RTL

- Downstream of the gated reciprocal counter. Consumes its three raw gate-window counts: standard-clock count, signal falling-edge count, and high-time count.
- Converts them to integer frequency in Hz and duty cycle in permille, for display/UART stages.
- Uses one sequential shift-subtract divider, time-shared between both quotients.
- Runs in the standard-clock domain. The counts are static for roughly one gate period between updates.

---
 rtl/freq_result_calc_pkg.sv | 27 ++
 rtl/freq_result_calc_seq_divider.sv | 80 ++++++++
 rtl/freq_result_calc.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/freq_result_calc_pkg.sv
// Shared constants, FSM encoding and measurement payload for the frequency/duty
// result stage that sits behind the gated reciprocal counter.
package freq_result_calc_pkg;

    // Counter gate terminal count; GATE_CNT_MAX+1 clocks at FS_HZ_DEF is a 1 s half-period.
    localparam int unsigned GATE_CNT_MAX   = 49_999_999;
    localparam int unsigned FS_HZ_DEF      = GATE_CNT_MAX + 1;
    localparam int unsigned DUTY_SCALE_DEF = 1000;
    localparam int unsigned DIV_W_DEF      = 64;
    localparam int unsigned CNT_W          = 32;
    localparam int unsigned DUTY_W         = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV_F = 3'd2,
        ST_DIV_D = 3'd3,
        ST_DONE  = 3'd4
    } calc_state_e;

    typedef struct packed {
        logic [CNT_W-1:0] fs;
        logic [CNT_W-1:0] fx;
        logic [CNT_W-1:0] duty;
    } meas_t;

endpackage

// File: rtl/freq_result_calc_seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per clock, DIV_W clocks per
// division. The start cycle already performs the first iteration on the inputs.
module freq_result_calc_seq_divider
    import freq_result_calc_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk_fs,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             active,
    output logic             done_c
);

    localparam int unsigned IT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] dq_q, dq_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dvs_q, dvs_d;
    logic [IT_W-1:0]  it_q, it_d;
    logic             run_q, run_d;

    logic [DIV_W-1:0] src_dq;
    logic [CNT_W-1:0] src_rem;
    logic [CNT_W-1:0] src_dvs;
    logic [CNT_W:0]   trial;
    logic             q_bit;

    // Dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
    always_comb begin
        src_dq  = start ? dividend : dq_q;
        src_rem = start ? '0 : rem_q;
        src_dvs = start ? divisor : dvs_q;
        trial   = {src_rem, src_dq[DIV_W-1]};
        // A zero divisor never produces a quotient bit, so the result drains to 0.
        q_bit   = (src_dvs != '0) && (trial >= {1'b0, src_dvs});

        dq_d   = dq_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        it_d   = it_q;
        run_d  = run_q;
        done_c = 1'b0;

        if (start || run_q) begin
            dq_d  = {src_dq[DIV_W-2:0], q_bit};
            rem_d = q_bit ? CNT_W'(trial - {1'b0, src_dvs}) : trial[CNT_W-1:0];
            dvs_d = src_dvs;
            it_d  = start ? IT_W'(1) : it_q + IT_W'(1);
            run_d = 1'b1;
            if (it_d == IT_W'(DIV_W)) begin
                run_d  = 1'b0;
                done_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_fs) begin
        if (rst) begin
            dq_q  <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            it_q  <= '0;
            run_q <= 1'b0;
        end else begin
            dq_q  <= dq_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            it_q  <= it_d;
            run_q <= run_d;
        end
    end

    assign quotient = dq_q;
    assign active   = run_q;

endmodule

// File: rtl/freq_result_calc.sv
// Converts raw gate-window counts into frequency (Hz) and duty (permille) using
// one time-shared sequential divider; recomputes only when the counts change.
module freq_result_calc
    import freq_result_calc_pkg::*;
#(
    parameter int unsigned FS_HZ      = FS_HZ_DEF,
    parameter int unsigned DUTY_SCALE = DUTY_SCALE_DEF,
    parameter int unsigned DIV_W      = DIV_W_DEF
) (
    input  logic              clk_fs,
    input  logic              rst,
    input  logic [CNT_W-1:0]  fs_cnt_buff,
    input  logic [CNT_W-1:0]  fx_cnt_buff,
    input  logic [CNT_W-1:0]  duty_cycle_data,
    output logic [CNT_W-1:0]  freq_hz,
    output logic [DUTY_W-1:0] duty_permille,
    output logic              result_valid,
    output logic              busy,
    output logic              div_zero
);

    calc_state_e       state_q, state_d;
    meas_t             snap_q, snap_d;
    meas_t             meas_in;
    logic [DIV_W-1:0]  num_f_q, num_f_d;
    logic [DIV_W-1:0]  num_d_q, num_d_d;
    logic [DIV_W-1:0]  quo_f_q, quo_f_d;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              zero_q, zero_d;

    logic              div_start_c;
    logic [DIV_W-1:0]  div_dividend_c;
    logic [DIV_W-1:0]  div_quotient;
    logic              div_active;
    logic              div_done_c;

    assign meas_in = '{fs: fs_cnt_buff, fx: fx_cnt_buff, duty: duty_cycle_data};

    freq_result_calc_seq_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk_fs   (clk_fs),
        .rst      (rst),
        .start    (div_start_c),
        .dividend (div_dividend_c),
        .divisor  (snap_q.fs),
        .quotient (div_quotient),
        .active   (div_active),
        .done_c   (div_done_c)
    );

    always_comb begin
        state_d        = state_q;
        snap_d         = snap_q;
        num_f_d        = num_f_q;
        num_d_d        = num_d_q;
        quo_f_d        = quo_f_q;
        freq_d         = freq_q;
        duty_d         = duty_q;
        zero_d         = zero_q;
        valid_d        = 1'b0;
        div_start_c    = 1'b0;
        div_dividend_c = num_f_q;

        unique case (state_q)
            ST_IDLE: begin
                // busy_q still covers the result cycle, so a pending change waits one more clock.
                if (!busy_q && (meas_in != snap_q)) begin
                    snap_d  = meas_in;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                num_f_d = DIV_W'(64'(snap_q.fx) * 64'(FS_HZ));
                num_d_d = DIV_W'(64'(snap_q.duty) * 64'(DUTY_SCALE));
                state_d = ST_DIV_F;
            end
            ST_DIV_F: begin
                div_start_c = !div_active;
                if (div_done_c) begin
                    state_d = ST_DIV_D;
                end
            end
            ST_DIV_D: begin
                div_start_c    = !div_active;
                div_dividend_c = num_d_q;
                // Frequency quotient must be parked before the divider is reloaded.
                if (div_start_c) begin
                    quo_f_d = div_quotient;
                end
                if (div_done_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                if (snap_q.fs == '0) begin
                    freq_d = '0;
                    duty_d = '0;
                    zero_d = 1'b1;
                end else begin
                    freq_d = (quo_f_q > DIV_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                                : CNT_W'(quo_f_q);
                    duty_d = (div_quotient > DIV_W'(DUTY_SCALE)) ? DUTY_W'(DUTY_SCALE)
                                                                  : DUTY_W'(div_quotient);
                    zero_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
    end

    always_ff @(posedge clk_fs) begin
        if (rst) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            num_f_q <= '0;
            num_d_q <= '0;
            quo_f_q <= '0;
            freq_q  <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            num_f_q <= num_f_d;
            num_d_q <= num_d_d;
            quo_f_q <= quo_f_d;
            freq_q  <= freq_d;
            duty_q  <= duty_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            zero_q  <= zero_d;
        end
    end

    assign freq_hz       = freq_q;
    assign duty_permille = duty_q;
    assign result_valid  = valid_q;
    assign busy          = busy_q;
    assign div_zero      = zero_q;

endmodule
